// File: rtl/uart_tx_buffered_if.sv
// Core-side bundle of the buffered UART transmitter.
// The master writes bytes in; the slave reports FIFO/line status.
interface uart_tx_buffered_if #(
  parameter int data_width = 8
);
  logic [data_width-1:0] data_in;
  logic                  write_enable;
  logic                  full;
  logic                  empty;
  logic                  overflow;
  logic                  busy;
  logic                  tx;

  modport master (
    output data_in,
    output write_enable,
    input  full,
    input  empty,
    input  overflow,
    input  busy,
    input  tx
  );

  modport slave (
    input  data_in,
    input  write_enable,
    output full,
    output empty,
    output overflow,
    output busy,
    output tx
  );
endinterface

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: power-of-two FIFO
// drained into a start/data/stop serialiser.
module uart_tx_buffered #(
  parameter int data_width           = 8,
  parameter int length_as_power_of_2 = 4,
  parameter int clocks_per_bit       = 16
) (
  input logic               clock,
  input logic               reset,
  uart_tx_buffered_if.slave bus
);
  localparam int depth = 2 ** length_as_power_of_2;
  localparam int lw    = length_as_power_of_2;
  localparam int bw    = $clog2(clocks_per_bit);
  localparam int iw    = (data_width > 1) ? $clog2(data_width) : 1;

  localparam logic [bw-1:0] baud_last =
    bw'(clocks_per_bit - 1);
  localparam logic [iw-1:0] index_last =
    iw'(data_width - 1);
  localparam logic [lw:0] count_full = (lw + 1)'(depth);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic [data_width-1:0] mem [depth];
  logic [lw-1:0]         rd_ptr;
  logic [lw-1:0]         wr_ptr;
  logic [lw:0]           count;

  state_t                state;
  state_t                state_n;
  logic [bw-1:0]         baud;
  logic [bw-1:0]         baud_n;
  logic [iw-1:0]         index;
  logic [iw-1:0]         index_n;
  logic [data_width-1:0] shift;
  logic [data_width-1:0] shift_n;
  logic                  tx_q;
  logic                  tx_n;
  logic                  overflow_q;

  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  drop;
  logic                  pop;

  assign full  = (count == count_full);
  assign empty = (count == '0);
  assign push  = bus.write_enable && !full;
  assign drop  = bus.write_enable && full;

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.overflow = overflow_q;
  assign bus.busy     = (state != IDLE);
  assign bus.tx       = tx_q;

  always_comb begin
    state_n = state;
    baud_n  = baud;
    index_n = index;
    shift_n = shift;
    tx_n    = tx_q;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = START;
          tx_n    = 1'b0;
          baud_n  = '0;
        end
      end
      START: begin
        if (baud == baud_last) begin
          state_n = DATA;
          baud_n  = '0;
          index_n = '0;
          tx_n    = shift[0];
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      DATA: begin
        if (baud == baud_last) begin
          baud_n = '0;
          if (index == index_last) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            shift_n = shift >> 1;
            index_n = index + 1'b1;
            tx_n    = shift_n[0];
          end
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      STOP: begin
        if (baud == baud_last) begin
          baud_n = '0;
          // chain straight into the next start bit, no idle gap
          if (!empty) begin
            pop     = 1'b1;
            state_n = START;
            tx_n    = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (pop) shift_n = mem[rd_ptr];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      baud       <= '0;
      index      <= '0;
      shift      <= '0;
      tx_q       <= 1'b1;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state <= state_n;
      baud  <= baud_n;
      index <= index_n;
      shift <= shift_n;
      tx_q  <= tx_n;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (lw + 1)'(push)
                     - (lw + 1)'(pop);
      if (drop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= bus.data_in;
  end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: frame-position reference model,
// line decoder and per-scenario directed/random tests.
module tb_uart_tx_buffered;
  localparam int DW    = 8;
  localparam int L     = 2;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = (DW + 2) * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  uart_tx_buffered_if #(.data_width(DW)) bus ();

  uart_tx_buffered #(
    .data_width          (DW),
    .length_as_power_of_2(L),
    .clocks_per_bit      (CPB)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // reference: byte queue plus position inside the current frame
  logic [DW-1:0] mq[$];
  bit            m_active = 1'b0;
  bit            m_ovf    = 1'b0;
  int            m_pos    = 0;
  logic [DW-1:0] m_cur    = '0;
  int            m_n;
  bit            m_pop;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_active = 1'b0;
      m_pos    = 0;
      m_ovf    = 1'b0;
    end else begin
      m_n   = mq.size();
      m_pop = 1'b0;
      if (!m_active) begin
        if (m_n > 0) begin
          m_pop    = 1'b1;
          m_active = 1'b1;
          m_pos    = 0;
        end
      end else if (m_pos == FRAME - 1) begin
        if (m_n > 0) begin
          m_pop = 1'b1;
          m_pos = 0;
        end else begin
          m_active = 1'b0;
        end
      end else begin
        m_pos++;
      end
      if (bus.write_enable) begin
        if (m_n == DEPTH) m_ovf = 1'b1;
        else mq.push_back(bus.data_in);
      end
      if (m_pop) m_cur = mq.pop_front();
    end
  end

  function automatic logic model_tx();
    int b;
    if (!m_active) return 1'b1;
    b = m_pos / CPB;
    if (b == 0) return 1'b0;
    if (b > DW) return 1'b1;
    return m_cur[b-1];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (bus.tx !== model_tx()) begin
        errors++;
        $display("FAIL model_tx t=%0t got %b want %b",
                 $time, bus.tx, model_tx());
      end
      checks++;
      if (bus.busy !== m_active) begin
        errors++;
        $display("FAIL model_busy t=%0t got %b want %b",
                 $time, bus.busy, m_active);
      end
      checks++;
      if (bus.full !== (mq.size() == DEPTH)) begin
        errors++;
        $display("FAIL model_full t=%0t got %b want %b",
                 $time, bus.full, mq.size() == DEPTH);
      end
      checks++;
      if (bus.empty !== (mq.size() == 0)) begin
        errors++;
        $display("FAIL model_empty t=%0t got %b want %b",
                 $time, bus.empty, mq.size() == 0);
      end
      checks++;
      if (bus.overflow !== m_ovf) begin
        errors++;
        $display("FAIL model_ovf t=%0t got %b want %b",
                 $time, bus.overflow, m_ovf);
      end
    end
  end

  // line decoder: mid-bit sampling of every frame seen on tx
  logic [DW-1:0] rxq[$];
  bit            rx_active = 1'b0;
  int            rx_cnt    = 0;
  logic [DW-1:0] rx_byte   = '0;

  always @(negedge clk) begin
    if (rst || bus.busy !== 1'b1) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (bus.tx === 1'b0) begin
        rx_active = 1'b1;
        rx_cnt    = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % CPB == CPB / 2 && rx_cnt / CPB >= 1 &&
          rx_cnt / CPB <= DW)
        rx_byte[rx_cnt/CPB-1] = bus.tx;
      if (rx_cnt == FRAME - CPB / 2) begin
        rxq.push_back(rx_byte);
        rx_active = 1'b0;
      end
    end
  end

  task automatic do_reset();
    bus.write_enable = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rxq.delete();
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (bus.busy === 1'b0 && bus.empty === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.write_enable = 1'b0;
    bus.data_in = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    checks++;
    if (bus.tx !== 1'b1) begin
      errors++;
      $display("FAIL reset_tx got %b want 1", bus.tx);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b want 0", bus.busy);
    end
    checks++;
    if (bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL reset_empty got %b want 1", bus.empty);
    end
    checks++;
    if (bus.full !== 1'b0) begin
      errors++;
      $display("FAIL reset_full got %b want 0", bus.full);
    end
    checks++;
    if (bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf got %b want 0", bus.overflow);
    end
  endtask

  task automatic test_single();
    logic [DW-1:0] b;
    logic [DW+1:0] bits;
    b = 8'hA5;
    bits = {1'b1, b, 1'b0};
    do_reset();
    bus.data_in = b;
    bus.write_enable = 1'b1;
    @(negedge clk);
    bus.write_enable = 1'b0;
    checks++;
    if (bus.empty !== 1'b0) begin
      errors++;
      $display("FAIL single_empty_e got %b want 0", bus.empty);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.tx !== 1'b1) begin
      errors++;
      $display("FAIL single_idle_e got busy=%b tx=%b want 0 1",
               bus.busy, bus.tx);
    end
    @(negedge clk);
    checks++;
    if (bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL single_empty_e1 got %b want 1", bus.empty);
    end
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (bus.tx !== bits[i/CPB]) begin
        errors++;
        $display("FAIL single_tx cyc=%0d got %b want %b",
                 i, bus.tx, bits[i/CPB]);
      end
      checks++;
      if (bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL single_busy cyc=%0d got %b want 1",
                 i, bus.busy);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.tx !== 1'b1) begin
      errors++;
      $display("FAIL single_end got busy=%b tx=%b want 0 1",
               bus.busy, bus.tx);
    end
  endtask

  task automatic test_back_to_back();
    logic line [3*FRAME];
    bit busy_ok;
    logic [DW-1:0] got;
    busy_ok = 1'b1;
    do_reset();
    for (int k = 0; k <= 3 * FRAME; k++) begin
      bus.write_enable = (k < 3);
      bus.data_in = DW'(k + 1);
      @(negedge clk);
      if (k >= 1) begin
        line[k-1] = bus.tx;
        if (bus.busy !== 1'b1) busy_ok = 1'b0;
      end
    end
    bus.write_enable = 1'b0;
    checks++;
    if (!busy_ok) begin
      errors++;
      $display("FAIL b2b_busy got gap want continuous");
    end
    for (int j = 0; j < 3; j++) begin
      for (int b = 0; b < DW; b++)
        got[b] = line[FRAME*j + CPB*(b+1) + CPB/2];
      checks++;
      if (line[FRAME*j] !== 1'b0 ||
          line[FRAME*j+FRAME-1] !== 1'b1) begin
        errors++;
        $display("FAIL b2b_frame%0d got start=%b stop=%b want 0 1",
                 j, line[FRAME*j], line[FRAME*j+FRAME-1]);
      end
      checks++;
      if (got !== DW'(j + 1)) begin
        errors++;
        $display("FAIL b2b_data%0d got %h want %h",
                 j, got, DW'(j + 1));
      end
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end got busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] sent [6];
    bit ok;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      sent[i] = DW'($urandom);
      bus.data_in = sent[i];
      bus.write_enable = 1'b1;
      @(negedge clk);
      if (i == 4) begin
        checks++;
        if (bus.full !== 1'b1 || bus.overflow !== 1'b0) begin
          errors++;
          $display("FAIL ovf_fill got full=%b ovf=%b want 1 0",
                   bus.full, bus.overflow);
        end
      end
    end
    bus.write_enable = 1'b0;
    checks++;
    if (bus.overflow !== 1'b1 || bus.full !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set got ovf=%b full=%b want 1 1",
               bus.overflow, bus.full);
    end
    wait_idle(8 * FRAME, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL ovf_drain got timeout want idle");
    end
    checks++;
    if (rxq.size() != 5) begin
      errors++;
      $display("FAIL ovf_count got %0d want 5", rxq.size());
    end
    for (int i = 0; i < 5 && i < rxq.size(); i++) begin
      checks++;
      if (rxq[i] !== sent[i]) begin
        errors++;
        $display("FAIL ovf_order%0d got %h want %h",
                 i, rxq[i], sent[i]);
      end
    end
    checks++;
    if (bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky got %b want 1", bus.overflow);
    end
  endtask

  task automatic test_full_pop_edge();
    logic [DW-1:0] sent [5];
    bit ok;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      sent[i] = DW'($urandom);
      bus.data_in = sent[i];
      bus.write_enable = 1'b1;
      @(negedge clk);
    end
    bus.write_enable = 1'b0;
    repeat (FRAME - 4) @(negedge clk);
    checks++;
    if (bus.full !== 1'b1 || bus.overflow !== 1'b0 ||
        bus.tx !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL fpe_pre got full=%b ovf=%b tx=%b busy=%b want 1 0 1 1",
               bus.full, bus.overflow, bus.tx, bus.busy);
    end
    bus.data_in = DW'($urandom);
    bus.write_enable = 1'b1;
    @(negedge clk);
    bus.write_enable = 1'b0;
    checks++;
    if (bus.overflow !== 1'b1 || bus.full !== 1'b0 ||
        bus.empty !== 1'b0 || bus.tx !== 1'b0) begin
      errors++;
      $display("FAIL fpe_edge got ovf=%b full=%b empty=%b tx=%b want 1 0 0 0",
               bus.overflow, bus.full, bus.empty, bus.tx);
    end
    wait_idle(8 * FRAME, ok);
    checks++;
    if (!ok || rxq.size() != 5) begin
      errors++;
      $display("FAIL fpe_drain got ok=%b n=%0d want 1 5",
               ok, rxq.size());
    end
    for (int i = 0; i < 5 && i < rxq.size(); i++) begin
      checks++;
      if (rxq[i] !== sent[i]) begin
        errors++;
        $display("FAIL fpe_order%0d got %h want %h",
                 i, rxq[i], sent[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit quiet;
    rxq.delete();
    checks++;
    if (bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre_ovf got %b want 1", bus.overflow);
    end
    for (int i = 0; i < 3; i++) begin
      bus.data_in = DW'($urandom);
      bus.write_enable = 1'b1;
      @(negedge clk);
    end
    bus.write_enable = 1'b0;
    repeat (15) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.empty !== 1'b0) begin
      errors++;
      $display("FAIL mid_pre got busy=%b empty=%b want 1 0",
               bus.busy, bus.empty);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.tx !== 1'b1 || bus.busy !== 1'b0 ||
        bus.empty !== 1'b1 || bus.full !== 1'b0 ||
        bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got tx=%b busy=%b empty=%b full=%b ovf=%b want 1 0 1 0 0",
               bus.tx, bus.busy, bus.empty, bus.full, bus.overflow);
    end
    quiet = 1'b1;
    for (int c = 0; c < 2 * FRAME; c++) begin
      @(negedge clk);
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet || rxq.size() != 0) begin
      errors++;
      $display("FAIL mid_quiet got quiet=%b frames=%0d want 1 0",
               quiet, rxq.size());
    end
  endtask

  task automatic test_wrap();
    int i;
    int cyc;
    bit ok;
    i = 0;
    cyc = 0;
    do_reset();
    while (i < 20 && cyc < 4000) begin
      if (bus.full === 1'b0 && $urandom_range(0, 3) != 0) begin
        bus.data_in = DW'(8'h10 + i);
        bus.write_enable = 1'b1;
        i++;
      end else begin
        bus.write_enable = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.write_enable = 1'b0;
    checks++;
    if (i != 20) begin
      errors++;
      $display("FAIL wrap_push got %0d want 20", i);
    end
    wait_idle(8 * FRAME, ok);
    checks++;
    if (!ok || rxq.size() != 20) begin
      errors++;
      $display("FAIL wrap_count got ok=%b n=%0d want 1 20",
               ok, rxq.size());
    end
    for (int k = 0; k < 20 && k < rxq.size(); k++) begin
      checks++;
      if (rxq[k] !== DW'(8'h10 + k)) begin
        errors++;
        $display("FAIL wrap_data%0d got %h want %h",
                 k, rxq[k], DW'(8'h10 + k));
      end
    end
    checks++;
    if (bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL wrap_ovf got %b want 0", bus.overflow);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_pop_edge();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Buffered UART transmitter. It accepts bytes from the core side into an internal power-of-two FIFO and serialises them onto a single line as 8N1 frames (start bit, LSB-first data, one stop bit). It is the transmit-side counterpart of the buffered UART receive path, and the block that drains the byte buffer toward the pin.

## Interface
Parameters:
- data_width, 8: bits per frame payload and FIFO entry width.
- length_as_power_of_2, 4: FIFO depth is 2**length_as_power_of_2 entries.
- clocks_per_bit, 16: clock cycles per serial bit. Must be >= 2.

Ports:
- clock  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  data_width  byte to enqueue.
- write_enable  input  1  enqueue request, sampled each rising edge.
- full  output  1  FIFO holds 2**length_as_power_of_2 entries.
- empty  output  1  FIFO holds 0 entries.
- overflow  output  1  sticky; set when a write is dropped.
- busy  output  1  transmitter state is not IDLE.
- tx  output  1  serial line, registered, idle high.

## Operation
- FIFO storage:
  - Circular buffer with read and write pointers of length_as_power_of_2 bits, both wrapping naturally.
  - Occupancy counter is length_as_power_of_2+1 bits.
  - full = (count == depth); empty = (count == 0). Both are combinational from the counter.
- Push:
  - Accepted when write_enable && !full, evaluated on the pre-edge count.
  - write_enable while full drops the byte and sets overflow. This holds even if a pop occurs on the same edge.
- Pop:
  - Occurs only in the FSM transitions into START defined below.
  - Head is loaded into the shift register and the read pointer advances.
  - A simultaneous push and pop leaves count unchanged.
- FSM states: IDLE, START, DATA, STOP. A baud counter (clog2(clocks_per_bit) bits) counts 0..clocks_per_bit-1 in every non-IDLE state.
  - IDLE: tx=1. If count>0 (pre-edge): pop, go to START, tx<=0, baud<=0.
  - START: after clocks_per_bit cycles go to DATA, bit index=0, tx<=shift[0].
  - DATA: every clocks_per_bit cycles shift right and increment the bit index. After bit data_width-1 completes, go to STOP with tx<=1.
  - STOP: after clocks_per_bit cycles:
    - If count>0: pop and go directly to START with tx<=0. There is no idle gap.
    - Else: go to IDLE.
- overflow is cleared only by reset.
- Reset:
  - Applied at any time, including mid-frame.
  - Next edge: state=IDLE, tx=1, busy=0, count=0, pointers=0, full=0, empty=1, overflow=0, baud counter and bit index=0.
  - FIFO contents are discarded and a partial frame is abandoned. Data RAM is not cleared.

## Timing
- Push latency: write_enable high at edge E into an empty, idle block gives empty=0 after E and tx falling at edge E+1. busy rises at E+1.
- Frame length is exactly (data_width+2)*clocks_per_bit cycles. Each bit level holds for exactly clocks_per_bit cycles.
- Back-to-back frames: the stop bit of frame N is immediately followed by the start bit of frame N+1 when the FIFO is non-empty at the stop-bit end.
- Pop happens on the same edge tx goes low for that frame, so full can deassert there.
- busy falls on the edge the stop bit ends with an empty FIFO, and tx stays 1.
- The FIFO accepts one push per cycle regardless of FSM state.

## Test plan
- Single byte (clocks_per_bit=4, depth 4):
  - Stimulus: after reset, push 0xA5 at edge E.
  - Response: tx from E+1 = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; busy high for 40 cycles; empty=1 after E+1.
- Back-to-back:
  - Stimulus: push 0x01, 0x02, 0x03 on consecutive cycles.
  - Response: three contiguous 40-cycle frames with no idle cycle between stop and start; payloads in order; busy continuous.
- Overflow:
  - Stimulus: push 6 bytes on consecutive cycles while frame 1 is in progress.
  - Response: frame 1 is popped at the first edge; entries 2–5 fill the FIFO (full=1); the 6th is dropped and overflow=1 stays set.
  - Order out is bytes 1–5.
- Push into full on a pop edge:
  - Stimulus: with the FIFO full, assert write_enable on the edge a stop bit ends.
  - Response: byte dropped, overflow=1, count becomes depth-1.
- Wrap-around:
  - Stimulus: stream 20 bytes 0x10..0x23, pushing whenever !full.
  - Response: all 20 are transmitted in order; overflow stays 0.
- Reset mid-frame:
  - Stimulus: assert reset during DATA bit 3 with 2 bytes queued.
  - Response: next edge tx=1, busy=0, empty=1, full=0, overflow=0; no further frames until a new push.
